dup_rxdbuf: RTL

DUP11 Receiver Data Buffer (RXDBUF): the read-side counterpart of the transmitter data buffer. It accepts assembled characters from the DUP receiver engine and holds them in a 2-entry silo. It presents the head entry to the bus as the 16-bit RXDBUF register, with SOM/EOM/abort/CRC-error status and sticky overrun. It sits between the receiver deserializer and the DUP11 register-read multiplexer, and drives RXDONE into RXCSR.

---
 rtl/dup_rxdbuf_pkg.sv | 38 +++
 rtl/dup_rxdbuf.sv | 78 +++++++
 2 files changed

// File: rtl/dup_rxdbuf_pkg.sv
// Shared types and field positions for the DUP11 receiver data buffer.
// The image helper builds the bus-visible RXDBUF word from a silo entry.
package dup_rxdbuf_pkg;

   typedef struct packed {
      logic [7:0] dat;
      logic       som;
      logic       eom;
      logic       abrt;
      logic       crcer;
   } rx_entry_t;

   localparam int SILO_DEPTH = 2;

   localparam int RXERR_BIT  = 15;
   localparam int OVRN_BIT   = 14;
   localparam int RCRCER_BIT = 12;
   localparam int RXABRT_BIT = 10;
   localparam int RXEOM_BIT  = 9;
   localparam int RXSOM_BIT  = 8;

   // Entry fields read as zero when the silo is empty; the overrun bits never do.
   function automatic logic [15:0] rxdbuf_image(rx_entry_t e, logic valid, logic ovrn);
      logic [15:0] img;
      img = '0;
      if (valid) begin
         img[7:0]        = e.dat;
         img[RXSOM_BIT]  = e.som;
         img[RXEOM_BIT]  = e.eom;
         img[RXABRT_BIT] = e.abrt;
         img[RCRCER_BIT] = e.crcer;
      end
      img[OVRN_BIT]  = ovrn;
      img[RXERR_BIT] = ovrn | (valid & (e.crcer | e.abrt));
      return img;
   endfunction

endpackage

// File: rtl/dup_rxdbuf.sv
// DUP11 receiver data buffer: 2-entry silo between the receiver engine and
// the bus, presenting the head entry as RXDBUF with sticky overrun.
module dup_rxdbuf
   import dup_rxdbuf_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        dupINIT,
   input  logic        dupRXEN,
   input  logic        rxdbufREAD,
   input  logic        rxVALID,
   input  logic [7:0]  rxDATA,
   input  logic        rxSOM,
   input  logic        rxEOM,
   input  logic        rxABRT,
   input  logic        rxCRCZERO,
   output logic        dupRXDONE,
   output logic [15:0] regRXDBUF
);

   rx_entry_t  r_silo [SILO_DEPTH];
   logic [1:0] r_count;
   logic       r_head;
   logic       r_tail;
   logic       r_ovrn;

   logic       w_arrive;
   logic       w_empty;
   logic       w_full;
   logic       w_push;
   logic       w_pop;
   logic       w_overrun;
   rx_entry_t  w_new;

   assign w_empty   = (r_count == 2'd0);
   assign w_full    = (r_count == 2'd2);
   assign w_arrive  = rxVALID & dupRXEN;
   // A same-cycle read frees a slot, so a full silo still accepts the character.
   assign w_push    = w_arrive & (~w_full | rxdbufREAD);
   assign w_pop     = rxdbufREAD & ~w_empty;
   assign w_overrun = w_arrive & w_full & ~rxdbufREAD;

   assign w_new.dat   = rxDATA;
   assign w_new.som   = rxSOM;
   assign w_new.eom   = rxEOM;
   assign w_new.abrt  = rxABRT;
   assign w_new.crcer = rxEOM & ~rxCRCZERO;

   always_ff @(posedge clk) begin
      if (rst | dupINIT) begin
         r_count <= 2'd0;
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_ovrn  <= 1'b0;
         for (int i = 0; i < SILO_DEPTH; i++) begin
            r_silo[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_silo[r_tail] <= w_new;
            r_tail         <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
         if (w_pop) begin
            r_ovrn <= 1'b0;
         end else if (w_overrun) begin
            r_ovrn <= 1'b1;
         end
      end
   end

   assign dupRXDONE = ~w_empty;
   assign regRXDBUF = rxdbuf_image(r_silo[r_head], ~w_empty, r_ovrn);

endmodule
